// File: rtl/mem_access_unit_if.sv
// Request/response and memory-bus bundle for the load/store access unit.
// The slave modport is the unit itself; the master modport is the
// environment (MEM stage plus the word-wide data memory).
interface mem_access_unit_if #(
   parameter int ADDR_W = 8
);
   // Request side
   logic              req;
   logic              is_store;
   logic [1:0]        size;
   logic              unsigned_ld;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   // Response side
   logic              busy;
   logic              done;
   logic              err;
   logic [31:0]       rdata;
   // Memory side
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [31:0]       mem_rdata;

   modport slave (
      input  req, is_store, size, unsigned_ld, addr, wdata, mem_rdata,
      output busy, done, err, rdata, mem_addr, mem_wdata, mem_we, mem_re
   );

   modport master (
      output req, is_store, size, unsigned_ld, addr, wdata, mem_rdata,
      input  busy, done, err, rdata, mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

// File: rtl/mem_access_unit.sv
// CPU-side load/store initiator for a word-wide data memory with one cycle
// of read latency. Sub-word stores are done as read-modify-write; loads are
// lane-extracted and sign/zero-extended. One request in flight at a time.
module mem_access_unit #(
   parameter int ADDR_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   mem_access_unit_if.slave   bus
);

   typedef enum logic [2:0] {IDLE, RD, LAT, WR, DONE} state_t;

   state_t      state;
   logic        isStore;
   logic [1:0]  sizeQ;
   logic        unsignedQ;
   logic [1:0]  laneQ;
   logic [31:0] wdataQ;

   logic        illegal;
   logic [7:0]  byteSel;
   logic [15:0] halfSel;
   logic [31:0] mergedWord;
   logic [31:0] loadValue;

   // Reject the reserved size code and any access not aligned to its own size
   always_comb begin
      illegal = (bus.size == 2'b11) ||
                (bus.size == 2'b01 && bus.addr[0]) ||
                (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
   end

   // Lane selection on the word returned by memory: extended load value and
   // the store merge that leaves the untouched lanes as they were read
   always_comb begin
      byteSel    = bus.mem_rdata[{laneQ, 3'b000} +: 8];
      halfSel    = bus.mem_rdata[{laneQ[1], 4'b0000} +: 16];
      mergedWord = bus.mem_rdata;
      loadValue  = bus.mem_rdata;
      if (sizeQ == 2'b00) begin
         mergedWord[{laneQ, 3'b000} +: 8] = wdataQ[7:0];
         loadValue = {{24{byteSel[7] & ~unsignedQ}}, byteSel};
      end else if (sizeQ == 2'b01) begin
         mergedWord[{laneQ[1], 4'b0000} +: 16] = wdataQ[15:0];
         loadValue = {{16{halfSel[15] & ~unsignedQ}}, halfSel};
      end
   end

   // Access sequencer; every output is a register so nothing follows req
   // combinationally, and reset abandons an access before any write issues
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         isStore       <= 1'b0;
         sizeQ         <= 2'b00;
         unsignedQ     <= 1'b0;
         laneQ         <= 2'b00;
         wdataQ        <= 32'h0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         bus.rdata     <= 32'h0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= 32'h0;
         bus.mem_we    <= 1'b0;
         bus.mem_re    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req) begin
                  isStore      <= bus.is_store;
                  sizeQ        <= bus.size;
                  unsignedQ    <= bus.unsigned_ld;
                  laneQ        <= bus.addr[1:0];
                  wdataQ       <= bus.wdata;
                  bus.mem_addr <= bus.addr[ADDR_W+1:2];
                  bus.busy     <= 1'b1;
                  if (illegal) begin
                     state    <= DONE;
                     bus.done <= 1'b1;
                     bus.err  <= 1'b1;
                  end else if (bus.is_store && bus.size == 2'b10) begin
                     state         <= WR;
                     bus.mem_we    <= 1'b1;
                     bus.mem_wdata <= bus.wdata;
                  end else begin
                     state      <= RD;
                     bus.mem_re <= 1'b1;
                  end
               end
            end
            RD: begin
               bus.mem_re <= 1'b0;
               state      <= LAT;
            end
            LAT: begin
               if (isStore) begin
                  bus.mem_wdata <= mergedWord;
                  bus.mem_we    <= 1'b1;
                  state         <= WR;
               end else begin
                  bus.rdata <= loadValue;
                  bus.done  <= 1'b1;
                  state     <= DONE;
               end
            end
            WR: begin
               bus.mem_we <= 1'b0;
               bus.done   <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               bus.done <= 1'b0;
               bus.err  <= 1'b0;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.done   <= 1'b0;
               bus.err    <= 1'b0;
               bus.busy   <= 1'b0;
               bus.mem_we <= 1'b0;
               bus.mem_re <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a behavioural one-cycle-latency memory,
// a scoreboard of expected completions, and a linear list of requests.
module tb_mem_access_unit;

   typedef struct {
      string       tag;
      logic        err;
      logic [31:0] rdata;
      int          acceptCycle;
      int          latency;
      int          reExp;
      int          weExp;
   } exp_t;

   logic        clock;
   logic        reset;
   int          total;
   int          bad;
   int          cycleCount;
   int          reCount;
   int          weCount;
   int          doneCount;
   logic [7:0]  curExpAddr;
   logic [31:0] memArr [0:255];
   exp_t        sb [$];

   mem_access_unit_if #(.ADDR_W(8)) bus ();

   mem_access_unit #(.ADDR_W(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Cycle counter used to measure request-to-done latency
   always @(posedge clock) cycleCount <= cycleCount + 1;

   // Word memory: write on mem_we, read data appears the cycle after mem_re
   always @(posedge clock) begin
      if (bus.mem_we) memArr[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= memArr[bus.mem_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Monitor: count memory strobes, check their address, retire completions
   always @(negedge clock) begin
      if (reset) begin
         reCount = 0;
         weCount = 0;
      end else begin
         if (bus.mem_re) begin
            reCount++;
            checkOutput("re_addr", 32'(bus.mem_addr), 32'(curExpAddr));
         end
         if (bus.mem_we) begin
            weCount++;
            checkOutput("we_addr", 32'(bus.mem_addr), 32'(curExpAddr));
         end
         if (bus.done) begin
            doneCount++;
            if (sb.size() == 0) begin
               checkOutput("unexpected_done", 32'(sb.size()), 32'd1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput({e.tag, "_err"}, 32'(bus.err), 32'(e.err));
               checkOutput({e.tag, "_rdata"}, bus.rdata, e.rdata);
               checkOutput({e.tag, "_lat"}, 32'(cycleCount - e.acceptCycle + 1),
                           32'(e.latency));
               checkOutput({e.tag, "_re"}, 32'(reCount), 32'(e.reExp));
               checkOutput({e.tag, "_we"}, 32'(weCount), 32'(e.weExp));
            end
            reCount = 0;
            weCount = 0;
         end
      end
   end

   // Issue one request once the unit is idle and record what it should do
   task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic un,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic expErr, input logic [31:0] expRd,
                                input int lat, input int reExp, input int weExp,
                                input string tag, input bit holdReq);
      int   guard;
      exp_t e;
      guard = 0;
      @(negedge clock);
      while (bus.busy && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      if (bus.busy) checkOutput({tag, "_idle_timeout"}, 32'(bus.busy), 32'd0);
      bus.is_store    = st;
      bus.size        = sz;
      bus.unsigned_ld = un;
      bus.addr        = a;
      bus.wdata       = wd;
      bus.req         = 1'b1;
      curExpAddr      = a[9:2];
      @(posedge clock);
      #1;
      e.tag         = tag;
      e.err         = expErr;
      e.rdata       = expRd;
      e.acceptCycle = cycleCount;
      e.latency     = lat;
      e.reExp       = reExp;
      e.weExp       = weExp;
      sb.push_back(e);
      if (!holdReq) bus.req = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 30) begin
         @(negedge clock);
         guard++;
      end
      @(negedge clock);
      checkOutput({tag, "_drain"}, 32'(sb.size()), 32'd0);
   endtask

   // Directed sequence
   initial begin
      int doneBefore;
      total       = 0;
      bad         = 0;
      cycleCount  = 0;
      reCount     = 0;
      weCount     = 0;
      doneCount   = 0;
      curExpAddr  = 8'h00;
      reset       = 1'b1;
      bus.req         = 1'b0;
      bus.is_store    = 1'b0;
      bus.size        = 2'b00;
      bus.unsigned_ld = 1'b0;
      bus.addr        = 32'h0;
      bus.wdata       = 32'h0;
      bus.mem_rdata   = 32'h0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("rst_busy",   32'(bus.busy),      32'd0);
      checkOutput("rst_done",   32'(bus.done),      32'd0);
      checkOutput("rst_err",    32'(bus.err),       32'd0);
      checkOutput("rst_we",     32'(bus.mem_we),    32'd0);
      checkOutput("rst_re",     32'(bus.mem_re),    32'd0);
      checkOutput("rst_rdata",  bus.rdata,          32'h0);
      checkOutput("rst_maddr",  32'(bus.mem_addr),  32'h0);
      checkOutput("rst_mwdata", bus.mem_wdata,      32'h0);
      reset = 1'b0;

      // Word store then word load
      applyStimulus(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2, 0, 1, "sw10", 0);
      waitDone("sw10");
      checkOutput("mem4", memArr[4], 32'hDEADBEEF);
      applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, 1, 0, "lw10", 0);
      waitDone("lw10");

      // Byte store by read-modify-write, signed and unsigned byte loads
      applyStimulus(1, 2'b10, 0, 32'h20, 32'h11223344, 0, 32'hDEADBEEF, 2, 0, 1, "sw20", 0);
      applyStimulus(1, 2'b00, 0, 32'h22, 32'h000000AB, 0, 32'hDEADBEEF, 4, 1, 1, "sb22", 0);
      waitDone("sb22");
      checkOutput("mem8_sb", memArr[8], 32'h11AB3344);
      applyStimulus(0, 2'b00, 0, 32'h22, 32'h0, 0, 32'hFFFFFFAB, 3, 1, 0, "lb22", 0);
      applyStimulus(0, 2'b00, 1, 32'h22, 32'h0, 0, 32'h000000AB, 3, 1, 0, "lbu22", 0);

      // Halfword store, signed and unsigned halfword loads
      applyStimulus(1, 2'b10, 0, 32'h20, 32'h11223344, 0, 32'h000000AB, 2, 0, 1, "sw20b", 0);
      applyStimulus(1, 2'b01, 0, 32'h22, 32'h00008001, 0, 32'h000000AB, 4, 1, 1, "sh22", 0);
      waitDone("sh22");
      checkOutput("mem8_sh", memArr[8], 32'h80013344);
      applyStimulus(0, 2'b01, 0, 32'h22, 32'h0, 0, 32'hFFFF8001, 3, 1, 0, "lh22", 0);
      applyStimulus(0, 2'b01, 1, 32'h22, 32'h0, 0, 32'h00008001, 3, 1, 0, "lhu22", 0);

      // Top byte lane
      applyStimulus(1, 2'b00, 0, 32'h23, 32'h00000055, 0, 32'h00008001, 4, 1, 1, "sb23", 0);
      applyStimulus(0, 2'b00, 0, 32'h23, 32'h0, 0, 32'h00000055, 3, 1, 0, "lb23", 0);
      waitDone("lane3");
      checkOutput("mem8_sb3", memArr[8], 32'h55013344);

      // Misaligned and illegal requests finish in one cycle without traffic
      applyStimulus(0, 2'b10, 0, 32'h6, 32'h0, 1, 32'h00000055, 1, 0, 0, "lw6", 0);
      applyStimulus(1, 2'b01, 0, 32'h3, 32'hFFFF, 1, 32'h00000055, 1, 0, 0, "sh3", 0);
      applyStimulus(0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h00000055, 1, 0, 0, "sz11", 0);
      waitDone("illegal");
      checkOutput("mem8_kept", memArr[8], 32'h55013344);

      // req held high across three loads: one done and one read per load
      doneBefore = doneCount;
      applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, 1, 0, "hold1", 1);
      applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, 1, 0, "hold2", 1);
      applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, 1, 0, "hold3", 0);
      waitDone("hold");
      repeat (4) @(negedge clock);
      checkOutput("hold_dones", 32'(doneCount - doneBefore), 32'd3);

      // Upper address bits wrap onto the word array
      applyStimulus(1, 2'b10, 0, 32'h4, 32'hCAFEF00D, 0, 32'hDEADBEEF, 2, 0, 1, "sw4", 0);
      applyStimulus(0, 2'b10, 0, 32'h404, 32'h0, 0, 32'hCAFEF00D, 3, 1, 0, "lw404", 0);
      waitDone("wrap");

      // Reset in the middle of a byte store's read phase
      @(negedge clock);
      bus.is_store    = 1'b1;
      bus.size        = 2'b00;
      bus.unsigned_ld = 1'b0;
      bus.addr        = 32'h20;
      bus.wdata       = 32'h00000077;
      bus.req         = 1'b1;
      curExpAddr      = 8'h08;
      @(posedge clock);
      #1;
      bus.req = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      checkOutput("abort_busy", 32'(bus.busy),   32'd0);
      checkOutput("abort_done", 32'(bus.done),   32'd0);
      checkOutput("abort_we",   32'(bus.mem_we), 32'd0);
      repeat (3) @(negedge clock);
      checkOutput("abort_mem8", memArr[8], 32'h55013344);
      reset = 1'b0;
      applyStimulus(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h55013344, 3, 1, 0, "lw20", 0);
      waitDone("after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
